// File: rtl/ps2_note_decoder_if.sv
// ps2_note_decoder_if: bundles the PS/2 pins and the note outputs of ps2_note_decoder.
//   ps2_clk, ps2_dat : raw PS/2 lines, asynchronous to the system clock
//   ascii_val [6:0]  : ASCII of the held note key, 0 when none is held
//   key_held         : high while ascii_val is non-zero
//   key_valid        : one-cycle pulse when ascii_val takes a new non-zero value
//   frame_error      : one-cycle pulse on a discarded frame
// Modports: master = decoder side, slave = keyboard/display side.
interface ps2_note_decoder_if;
  logic       ps2_clk;
  logic       ps2_dat;
  logic [6:0] ascii_val;
  logic       key_held;
  logic       key_valid;
  logic       frame_error;

  modport master (
    input  ps2_clk,
    input  ps2_dat,
    output ascii_val,
    output key_held,
    output key_valid,
    output frame_error
  );

  modport slave (
    output ps2_clk,
    output ps2_dat,
    input  ascii_val,
    input  key_held,
    input  key_valid,
    input  frame_error
  );
endinterface

// File: rtl/ps2_note_decoder.sv
// ps2_note_decoder: PS/2 keyboard frame receiver and monophonic note-key decoder.
// Ports:
//   clock  : system clock, all logic on its rising edge
//   reset  : synchronous active-high reset
//   bus    : ps2_note_decoder_if.master (ps2_clk/ps2_dat in; ascii_val, key_held,
//            key_valid, frame_error out)
// Parameter TIMEOUT_CYCLES: cycles without a PS/2 fall mid-frame before the frame is aborted.
// Optional macro PS2_PARITY_CHECK_EN: when defined, frames with bad odd parity are discarded.
module ps2_note_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input logic               clock,
  input logic               reset,
  ps2_note_decoder_if.master bus
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} rx_state_e;

  // Synchronisers; reset to the idle-high line level so no fall is seen out of reset.
  logic clk_s1, clk_s2, clk_s3, dat_s1, dat_s2;
  logic fall;

  always_ff @(posedge clock) begin
    if (reset) begin
      {clk_s1, clk_s2, clk_s3} <= 3'b111;
      {dat_s1, dat_s2}         <= 2'b11;
    end else begin
      {clk_s1, clk_s2, clk_s3} <= {bus.ps2_clk, clk_s1, clk_s2};
      {dat_s1, dat_s2}         <= {bus.ps2_dat, dat_s1};
    end
  end

  assign fall = ~clk_s2 & clk_s3;

  // Receiver
  rx_state_e       state_q, state_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            par_q, par_d;
  logic            byte_stb_q, byte_stb_d;
  logic            frame_err_q, frame_err_d;
  logic [CntW-1:0] tmo_q, tmo_d;
  logic            timeout_hit;
  logic            par_ok;

`ifdef PS2_PARITY_CHECK_EN
  assign par_ok = ^{shift_q, par_q};
`else
  logic unused_par;
  assign unused_par = par_q;
  assign par_ok     = 1'b1;
`endif

  assign timeout_hit = (state_q != StIdle) && (tmo_q == CntW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    par_d       = par_q;
    byte_stb_d  = 1'b0;
    frame_err_d = 1'b0;
    tmo_d       = (state_q == StIdle || fall) ? '0 : tmo_q + 1'b1;
    if (timeout_hit) begin
      state_d     = StIdle;
      frame_err_d = 1'b1;
      tmo_d       = '0;
    end else if (fall) begin
      unique case (state_q)
        StIdle: begin
          if (!dat_s2) begin
            state_d   = StData;
            bit_cnt_d = 3'd0;
          end
        end
        StData: begin
          shift_d   = {dat_s2, shift_q[7:1]};  // LSB arrives first
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = StParity;
        end
        StParity: begin
          par_d   = dat_s2;
          state_d = StStop;
        end
        StStop: begin
          state_d = StIdle;
          if (dat_s2 && par_ok) byte_stb_d  = 1'b1;
          else                  frame_err_d = 1'b1;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      byte_stb_q  <= 1'b0;
      frame_err_q <= 1'b0;
      tmo_q       <= '0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      byte_stb_q  <= byte_stb_d;
      frame_err_q <= frame_err_d;
      tmo_q       <= tmo_d;
    end
  end

  // Byte decoder
  function automatic logic [6:0] scan_to_ascii(input logic [7:0] code);
    case (code)
      8'h15:   return 7'd81;
      8'h1D:   return 7'd87;
      8'h24:   return 7'd69;
      8'h2D:   return 7'd82;
      8'h2C:   return 7'd84;
      8'h35:   return 7'd89;
      8'h3C:   return 7'd85;
      8'h43:   return 7'd73;
      8'h44:   return 7'd79;
      8'h4D:   return 7'd80;
      8'h1C:   return 7'd65;
      8'h1B:   return 7'd83;
      8'h23:   return 7'd68;
      8'h2B:   return 7'd70;
      8'h34:   return 7'd71;
      8'h33:   return 7'd72;
      8'h3B:   return 7'd74;
      8'h42:   return 7'd75;
      8'h4B:   return 7'd76;
      default: return 7'd0;
    endcase
  endfunction

  logic [6:0] ascii_q, ascii_d, note;
  logic       key_valid_q, key_valid_d;
  logic       brk_q, brk_d, ext_q, ext_d;

  // shift_q stays stable while byte_stb_q is high: no data fall can follow a stop bit that fast.
  assign note = scan_to_ascii(shift_q);

  always_comb begin
    ascii_d     = ascii_q;
    key_valid_d = 1'b0;
    brk_d       = brk_q;
    ext_d       = ext_q;
    if (byte_stb_q) begin
      if (shift_q == 8'hE0) begin
        ext_d = 1'b1;
      end else if (shift_q == 8'hF0) begin
        brk_d = 1'b1;
      end else begin
        brk_d = 1'b0;
        ext_d = 1'b0;
        if (!ext_q && note != 7'd0) begin
          if (brk_q) begin
            if (note == ascii_q) ascii_d = 7'd0;
          end else if (note != ascii_q) begin
            ascii_d     = note;
            key_valid_d = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ascii_q     <= 7'd0;
      key_valid_q <= 1'b0;
      brk_q       <= 1'b0;
      ext_q       <= 1'b0;
    end else begin
      ascii_q     <= ascii_d;
      key_valid_q <= key_valid_d;
      brk_q       <= brk_d;
      ext_q       <= ext_d;
    end
  end

  assign bus.ascii_val   = ascii_q;
  assign bus.key_held    = (ascii_q != 7'd0);
  assign bus.key_valid   = key_valid_q;
  assign bus.frame_error = frame_err_q;

endmodule

// File: tb/tb_ps2_note_decoder.sv
// Self-checking bench for ps2_note_decoder: directed note sequences, timeout, mid-frame reset
// and randomized frames compared against a byte-level reference model.
module tb_ps2_note_decoder;
  localparam int unsigned Tmo = 100;
  localparam int          Hp  = 6;  // PS/2 half period in system clocks

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  ps2_note_decoder_if bus ();

  ps2_note_decoder #(.TIMEOUT_CYCLES(Tmo)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int cyc = 0;
  always @(posedge clock) cyc++;

  // Output monitor: pulse counts, last pulse cycles, pulses longer than one cycle.
  int   kv_seen = 0, fe_seen = 0, long_pulse = 0;
  int   last_kv_cyc = -1, last_fe_cyc = -1;
  logic kv_prev = 1'b0, fe_prev = 1'b0;
  always @(negedge clock) begin
    if (bus.key_valid) begin
      kv_seen++;
      last_kv_cyc = cyc;
      if (kv_prev) long_pulse++;
    end
    if (bus.frame_error) begin
      fe_seen++;
      last_fe_cyc = cyc;
      if (fe_prev) long_pulse++;
    end
    kv_prev = bus.key_valid;
    fe_prev = bus.frame_error;
  end

  int n_checks = 0, n_pass = 0;
  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
  endtask

  // Reference model: state of the keyboard protocol at the byte level.
  int note_map[int];
  int m_ascii = 0;
  bit m_brk = 0, m_ext = 0;
  int keys[19]  = '{'h15, 'h1D, 'h24, 'h2D, 'h2C, 'h35, 'h3C, 'h43, 'h44, 'h4D,
                    'h1C, 'h1B, 'h23, 'h2B, 'h34, 'h33, 'h3B, 'h42, 'h4B};
  int chars[19] = '{81, 87, 69, 82, 84, 89, 85, 73, 79, 80,
                    65, 83, 68, 70, 71, 72, 74, 75, 76};
  int unmapped[4] = '{'h16, 'h1E, 'h5A, 'h29};

  // Applies one accepted byte; returns the number of key_valid pulses it should cause.
  function automatic int model_byte(input int b);
    bit was_brk, was_ext;
    if (b == 'hE0) begin
      m_ext = 1;
      return 0;
    end
    if (b == 'hF0) begin
      m_brk = 1;
      return 0;
    end
    was_brk = m_brk;
    was_ext = m_ext;
    m_brk = 0;
    m_ext = 0;
    if (was_ext || !note_map.exists(b)) return 0;
    if (was_brk) begin
      if (note_map[b] == m_ascii) m_ascii = 0;
      return 0;
    end
    if (note_map[b] != m_ascii) begin
      m_ascii = note_map[b];
      return 1;
    end
    return 0;
  endfunction

  int last_fall = 0;

  task automatic ps2_bit(input logic b);
    @(posedge clock); #1 bus.ps2_dat = b;
    repeat (Hp) @(posedge clock);
    #1 bus.ps2_clk = 1'b0;
    last_fall = cyc;
    repeat (Hp) @(posedge clock);
    #1 bus.ps2_clk = 1'b1;
  endtask

  // Sends the first nbits of a frame (start, 8 data LSB first, parity, stop).
  task automatic send_frame(input logic [7:0] b, input logic par_flip, input logic stop,
                            input int nbits);
    logic [10:0] fr;
    fr = {stop, ~(^b) ^ par_flip, b, 1'b0};
    for (int i = 0; i < nbits; i++) ps2_bit(fr[i]);
  endtask

  task automatic send_and_check(input string tag, input logic [7:0] b, input logic par_flip,
                                input logic stop);
    int kv0, fe0, exp_kv;
    bit bad;
    kv0 = kv_seen;
    fe0 = fe_seen;
    bad = !stop;
`ifdef PS2_PARITY_CHECK_EN
    bad = bad | par_flip;
`endif
    exp_kv = bad ? 0 : model_byte(int'(b));
    send_frame(b, par_flip, stop, 11);
    repeat (8) @(posedge clock);
    @(negedge clock);
    check({tag, ":ascii"}, int'(bus.ascii_val), m_ascii);
    check({tag, ":held"}, int'(bus.key_held), int'(m_ascii != 0));
    check({tag, ":kv_pulses"}, kv_seen - kv0, exp_kv);
    check({tag, ":fe_pulses"}, fe_seen - fe0, int'(bad));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int kv0, fe0, lat, r, b;
    logic stop, flip;
    for (int i = 0; i < 19; i++) note_map[keys[i]] = chars[i];
    bus.ps2_clk = 1'b1;
    bus.ps2_dat = 1'b1;

    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst:ascii", int'(bus.ascii_val), 0);
    check("rst:held", int'(bus.key_held), 0);
    check("rst:kv", int'(bus.key_valid), 0);
    check("rst:fe", int'(bus.frame_error), 0);
    @(posedge clock); #1 reset = 1'b0;
    repeat (4) @(posedge clock);

    // Make then break of Q
    send_and_check("q_make", 8'h15, 1'b0, 1'b1);
    check("q_make:value", int'(bus.ascii_val), 81);
    lat = last_kv_cyc - last_fall;
    check("q_make:kv_latency_3to5", int'(lat >= 3 && lat <= 5), 1);
    send_and_check("q_brk0", 8'hF0, 1'b0, 1'b1);
    send_and_check("q_brk1", 8'h15, 1'b0, 1'b1);
    check("q_brk:value", int'(bus.ascii_val), 0);

    // Typematic repeat, new key, break of a non-held key
    send_and_check("w_make", 8'h1D, 1'b0, 1'b1);
    send_and_check("w_rep", 8'h1D, 1'b0, 1'b1);
    send_and_check("e_make", 8'h24, 1'b0, 1'b1);
    check("e_make:value", int'(bus.ascii_val), 69);
    send_and_check("w_brk0", 8'hF0, 1'b0, 1'b1);
    send_and_check("w_brk1", 8'h1D, 1'b0, 1'b1);
    check("w_brk:value", int'(bus.ascii_val), 69);
    send_and_check("e_brk0", 8'hF0, 1'b0, 1'b1);
    send_and_check("e_brk1", 8'h24, 1'b0, 1'b1);

    // Extended prefix suppresses the following byte
    send_and_check("ext0", 8'hE0, 1'b0, 1'b1);
    send_and_check("ext1", 8'h4B, 1'b0, 1'b1);
    check("ext1:value", int'(bus.ascii_val), 0);
    send_and_check("l_make", 8'h4B, 1'b0, 1'b1);
    check("l_make:value", int'(bus.ascii_val), 76);
    send_and_check("l_brk0", 8'hF0, 1'b0, 1'b1);
    send_and_check("l_brk1", 8'h4B, 1'b0, 1'b1);

    // Flipped parity bit
    send_and_check("par_flip", 8'h2B, 1'b1, 1'b1);
`ifdef PS2_PARITY_CHECK_EN
    check("par_flip:value", int'(bus.ascii_val), 0);
`else
    check("par_flip:value", int'(bus.ascii_val), 70);
`endif

    // Bad stop bit
    send_and_check("bad_stop", 8'h33, 1'b0, 1'b0);

    // Timeout after 4 data bits
    kv0 = kv_seen;
    fe0 = fe_seen;
    send_frame(8'h2C, 1'b0, 1'b1, 5);
    repeat (Tmo + 20) @(posedge clock);
    @(negedge clock);
    check("tmo:fe_pulses", fe_seen - fe0, 1);
    lat = last_fe_cyc - last_fall;
    check("tmo:fe_delay_100to105", int'(lat >= 100 && lat <= 105), 1);
    check("tmo:kv_pulses", kv_seen - kv0, 0);
    send_and_check("p_make", 8'h4D, 1'b0, 1'b1);
    check("p_make:value", int'(bus.ascii_val), 80);

    // Reset in the middle of a frame while S is held
    send_and_check("s_make", 8'h1B, 1'b0, 1'b1);
    check("s_make:value", int'(bus.ascii_val), 83);
    kv0 = kv_seen;
    fe0 = fe_seen;
    send_frame(8'h44, 1'b0, 1'b1, 5);
    @(posedge clock); #1 reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
    check("midrst:ascii", int'(bus.ascii_val), 0);
    check("midrst:held", int'(bus.key_held), 0);
    check("midrst:kv", int'(bus.key_valid), 0);
    check("midrst:fe", int'(bus.frame_error), 0);
    m_ascii = 0;
    m_brk = 0;
    m_ext = 0;
    repeat (Tmo + 20) @(posedge clock);
    @(negedge clock);
    check("midrst:kv_pulses", kv_seen - kv0, 0);
    check("midrst:fe_pulses", fe_seen - fe0, 0);

    // Randomized byte stream
    for (int n = 0; n < 60; n++) begin
      r = $urandom_range(0, 99);
      if (r < 20) b = 'hF0;
      else if (r < 28) b = 'hE0;
      else if (r < 34 && !m_brk && !m_ext) b = unmapped[$urandom_range(0, 3)];
      else b = keys[$urandom_range(0, 18)];
      stop = ($urandom_range(0, 9) != 0);
      flip = ($urandom_range(0, 9) == 0);
      send_and_check($sformatf("rnd%0d_%02h", n, b), 8'(b), flip, stop);
    end

    check("pulse_width", long_pulse, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
